// File: rtl/branch_pkg.sv
// Shared types for the branch predictor / resolver pair: queued prediction record
// and the 2-bit saturating counter encodings.
package branch_pkg;

   localparam int PC_W = 32;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   typedef struct packed {
      logic            taken;
      logic [PC_W-1:0] target;
      logic [PC_W-1:0] fallthru;
   } pred_entry_t;

endpackage

// File: rtl/branch_resolver_if.sv
// Fetch/execute-facing bus of the branch resolver.
// master = fetch + execute side, slave = resolver.
interface branch_resolver_if #(
   parameter int DEPTH = 4
);
   import branch_pkg::*;

   logic                     push_valid;
   logic                     push_ready;
   logic                     push_taken;
   logic [PC_W-1:0]          push_target;
   logic [PC_W-1:0]          push_fallthru;
   logic                     res_valid;
   logic                     res_taken;
   logic [PC_W-1:0]          res_target;
   logic                     upd_en;
   logic                     upd_decision;
   logic                     mispredict;
   logic [PC_W-1:0]          redirect_pc;
   logic [$clog2(DEPTH):0]   count;
   logic                     protocol_err;

   modport master (
      output push_valid, push_taken, push_target, push_fallthru,
      output res_valid, res_taken, res_target,
      input  push_ready, upd_en, upd_decision, mispredict, redirect_pc,
      input  count, protocol_err
   );

   modport slave (
      input  push_valid, push_taken, push_target, push_fallthru,
      input  res_valid, res_taken, res_target,
      output push_ready, upd_en, upd_decision, mispredict, redirect_pc,
      output count, protocol_err
   );
endinterface

// File: rtl/pred_fifo.sv
// In-order queue of predictions; flush empties it and wins over a same-edge push.
// Latency: head reflects a push on the next cycle. Backpressure: caller must not push when full.
// Storage is unreset; only pointers and count are cleared.
module pred_fifo
   import branch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clock,
   input  logic                   clear,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  pred_entry_t            din,
   output pred_entry_t            head,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);

   pred_entry_t    mem [DEPTH];
   logic [AW-1:0]  wp;
   logic [AW-1:0]  rp;

   always_ff @(posedge clock) begin
      if (push && !flush)
         mem[wp] <= din;
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else if (flush) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (push) wp <= wp + AW'(1);
         if (pop)  rp <= rp + AW'(1);
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   assign head = mem[rp];
endmodule

// File: rtl/branch_resolver.sv
// Checks each executed branch against its queued prediction; trains predictor, redirects on miss.
// Latency: update/mispredict/redirect registered, one cycle after res_valid.
// Backpressure: push_ready low when full or during a mispredict pulse; a missing resolve flushes.
module branch_resolver
   import branch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic               clock,
   input  logic               clear,
   branch_resolver_if.slave   bus
);
   localparam int CW = $clog2(DEPTH) + 1;

   pred_entry_t     head;
   pred_entry_t     din;
   logic [CW-1:0]   fifo_count;
   logic            push_acc;
   logic            res_acc;
   logic            miss;

   assign din        = '{taken: bus.push_taken, target: bus.push_target, fallthru: bus.push_fallthru};
   assign bus.push_ready = (fifo_count < CW'(DEPTH)) && !bus.mispredict;
   assign push_acc   = bus.push_valid && bus.push_ready;
   // A resolve against an empty queue has no prediction to check and is dropped.
   assign res_acc    = bus.res_valid && (fifo_count != '0);
   assign miss       = (head.taken != bus.res_taken) ||
                       (head.taken && bus.res_taken && (head.target != bus.res_target));

   pred_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock (clock),
      .clear (clear),
      .push  (push_acc),
      .pop   (res_acc),
      .flush (res_acc && miss),
      .din   (din),
      .head  (head),
      .count (fifo_count)
   );

   assign bus.count = fifo_count;

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         bus.upd_en       <= 1'b0;
         bus.upd_decision <= 1'b0;
         bus.mispredict   <= 1'b0;
         bus.redirect_pc  <= '0;
         bus.protocol_err <= 1'b0;
      end else begin
         bus.upd_en       <= res_acc;
         bus.upd_decision <= res_acc && bus.res_taken;
         bus.mispredict   <= res_acc && miss;
         if (res_acc && miss)
            bus.redirect_pc <= bus.res_taken ? bus.res_target : head.fallthru;
         else
            bus.redirect_pc <= '0;
         if (bus.res_valid && (fifo_count == '0))
            bus.protocol_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver with DEPTH=4: reset, hits, direction/target misses,
// full/wrap ordering, empty resolve and wrong-path push drop.
module tb_branch_resolver;
   import branch_pkg::*;

   localparam int DEPTH = 4;

   logic clock = 1'b0;
   logic clear = 1'b1;
   int   total = 0;
   int   bad   = 0;

   branch_resolver_if #(.DEPTH(DEPTH)) bif ();

   branch_resolver #(.DEPTH(DEPTH)) dut (
      .clock (clock),
      .clear (clear),
      .bus   (bif)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_push(input logic v, input logic tk, input logic [31:0] tgt, input logic [31:0] ft);
      bif.push_valid    = v;
      bif.push_taken    = tk;
      bif.push_target   = tgt;
      bif.push_fallthru = ft;
   endtask

   task automatic set_res(input logic v, input logic tk, input logic [31:0] tgt);
      bif.res_valid  = v;
      bif.res_taken  = tk;
      bif.res_target = tgt;
   endtask

   initial begin
      int nxt;
      int hd;
      set_push(1'b0, 1'b0, 32'h0, 32'h0);
      set_res(1'b0, 1'b0, 32'h0);
      tick();
      tick();
      clear = 1'b0;
      tick();

      chk("rst_count", 32'(bif.count), 32'd0);
      chk("rst_upd_en", 32'(bif.upd_en), 32'd0);
      chk("rst_upd_dec", 32'(bif.upd_decision), 32'd0);
      chk("rst_mispredict", 32'(bif.mispredict), 32'd0);
      chk("rst_redirect", bif.redirect_pc, 32'd0);
      chk("rst_perr", 32'(bif.protocol_err), 32'd0);
      chk("rst_ready", 32'(bif.push_ready), 32'd1);

      // Clear mid-stream: 3 queued, one resolved hit so upd_en is high, then 2 remain.
      for (int i = 0; i < 3; i++) begin
         set_push(1'b1, 1'b1, 32'h10 + 32'(i), 32'h20 + 32'(i));
         tick();
      end
      set_push(1'b0, 1'b0, 32'h0, 32'h0);
      chk("t1_count3", 32'(bif.count), 32'd3);
      set_res(1'b1, 1'b1, 32'h10);
      tick();
      set_res(1'b0, 1'b0, 32'h0);
      chk("t1_upd_pre", 32'(bif.upd_en), 32'd1);
      chk("t1_count2", 32'(bif.count), 32'd2);
      #2 clear = 1'b1;
      #1;
      chk("t1_clr_count", 32'(bif.count), 32'd0);
      chk("t1_clr_upd", 32'(bif.upd_en), 32'd0);
      chk("t1_clr_dec", 32'(bif.upd_decision), 32'd0);
      #1 clear = 1'b0;
      tick();

      // Correct-path resolve.
      set_push(1'b1, 1'b1, 32'h100, 32'h44);
      tick();
      set_push(1'b0, 1'b0, 32'h0, 32'h0);
      chk("t2_count1", 32'(bif.count), 32'd1);
      set_res(1'b1, 1'b1, 32'h100);
      tick();
      set_res(1'b0, 1'b0, 32'h0);
      chk("t2_upd_en", 32'(bif.upd_en), 32'd1);
      chk("t2_upd_dec", 32'(bif.upd_decision), 32'd1);
      chk("t2_mispredict", 32'(bif.mispredict), 32'd0);
      chk("t2_count0", 32'(bif.count), 32'd0);
      tick();
      chk("t2_upd_pulse", 32'(bif.upd_en), 32'd0);

      // Direction miss on the oldest of three; push during the pulse is refused.
      set_push(1'b1, 1'b0, 32'h0, 32'h48);
      tick();
      set_push(1'b1, 1'b1, 32'h50, 32'h4c);
      tick();
      set_push(1'b1, 1'b1, 32'h60, 32'h54);
      tick();
      set_push(1'b0, 1'b0, 32'h0, 32'h0);
      chk("t3_count3", 32'(bif.count), 32'd3);
      set_res(1'b1, 1'b1, 32'h200);
      tick();
      set_res(1'b0, 1'b0, 32'h0);
      chk("t3_mispredict", 32'(bif.mispredict), 32'd1);
      chk("t3_redirect", bif.redirect_pc, 32'h200);
      chk("t3_count0", 32'(bif.count), 32'd0);
      chk("t3_upd_dec", 32'(bif.upd_decision), 32'd1);
      chk("t3_ready_lo", 32'(bif.push_ready), 32'd0);
      set_push(1'b1, 1'b1, 32'h70, 32'h58);
      tick();
      set_push(1'b0, 1'b0, 32'h0, 32'h0);
      chk("t3_push_refused", 32'(bif.count), 32'd0);
      chk("t3_pulse_end", 32'(bif.mispredict), 32'd0);
      chk("t3_ready_hi", 32'(bif.push_ready), 32'd1);

      // Target miss.
      set_push(1'b1, 1'b1, 32'h300, 32'h84);
      tick();
      set_push(1'b0, 1'b0, 32'h0, 32'h0);
      set_res(1'b1, 1'b1, 32'h304);
      tick();
      set_res(1'b0, 1'b0, 32'h0);
      chk("t4_mispredict", 32'(bif.mispredict), 32'd1);
      chk("t4_redirect", bif.redirect_pc, 32'h304);
      tick();

      // Predicted taken, actually not taken: redirect to fallthru.
      set_push(1'b1, 1'b1, 32'h400, 32'h90);
      tick();
      set_push(1'b0, 1'b0, 32'h0, 32'h0);
      set_res(1'b1, 1'b0, 32'h0);
      tick();
      set_res(1'b0, 1'b0, 32'h0);
      chk("t4b_mispredict", 32'(bif.mispredict), 32'd1);
      chk("t4b_redirect", bif.redirect_pc, 32'h90);
      chk("t4b_upd_dec", 32'(bif.upd_decision), 32'd0);
      tick();

      // Not-taken / not-taken never misses, whatever the target.
      set_push(1'b1, 1'b0, 32'h111, 32'h94);
      tick();
      set_push(1'b0, 1'b0, 32'h0, 32'h0);
      set_res(1'b1, 1'b0, 32'h999);
      tick();
      set_res(1'b0, 1'b0, 32'h0);
      chk("t4c_no_miss", 32'(bif.mispredict), 32'd0);
      chk("t4c_upd_en", 32'(bif.upd_en), 32'd1);

      // Fill, then push+hit every cycle across the pointer wrap.
      for (int k = 0; k < DEPTH; k++) begin
         set_push(1'b1, 1'b1, 32'h1000 + 32'(k), 32'h2000 + 32'(k));
         tick();
      end
      chk("t5_full_count", 32'(bif.count), 32'(DEPTH));
      chk("t5_full_ready", 32'(bif.push_ready), 32'd0);
      // Full cycle: resolve pops, offered push (entry 4) is refused.
      set_push(1'b1, 1'b1, 32'h1004, 32'h2004);
      set_res(1'b1, 1'b1, 32'h1000);
      tick();
      chk("t5_full_pop_count", 32'(bif.count), 32'(DEPTH - 1));
      chk("t5_full_pop_hit", 32'(bif.mispredict), 32'd0);
      nxt = 4;
      hd  = 1;
      for (int i = 0; i < 2 * DEPTH; i++) begin
         set_push(1'b1, 1'b1, 32'h1000 + 32'(nxt), 32'h2000 + 32'(nxt));
         set_res(1'b1, 1'b1, 32'h1000 + 32'(hd));
         tick();
         nxt++;
         hd++;
         chk($sformatf("t5_wrap_hit%0d", i), 32'(bif.mispredict), 32'd0);
         chk($sformatf("t5_wrap_cnt%0d", i), 32'(bif.count), 32'(DEPTH - 1));
      end
      set_push(1'b0, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < DEPTH - 1; i++) begin
         set_res(1'b1, 1'b1, 32'h1000 + 32'(hd));
         tick();
         hd++;
         chk($sformatf("t5_drain_hit%0d", i), 32'(bif.mispredict), 32'd0);
      end
      set_res(1'b0, 1'b0, 32'h0);
      chk("t5_drained", 32'(bif.count), 32'd0);

      // Resolve with empty queue.
      set_res(1'b1, 1'b1, 32'h123);
      tick();
      set_res(1'b0, 1'b0, 32'h0);
      chk("t6_no_upd", 32'(bif.upd_en), 32'd0);
      chk("t6_no_miss", 32'(bif.mispredict), 32'd0);
      chk("t6_perr", 32'(bif.protocol_err), 32'd1);
      tick();
      tick();
      chk("t6_perr_sticky", 32'(bif.protocol_err), 32'd1);

      // Push alongside a mispredicting resolve is wrong-path and dropped.
      set_push(1'b1, 1'b1, 32'h500, 32'ha0);
      tick();
      set_push(1'b1, 1'b1, 32'h600, 32'ha4);
      set_res(1'b1, 1'b0, 32'h0);
      tick();
      set_push(1'b0, 1'b0, 32'h0, 32'h0);
      set_res(1'b0, 1'b0, 32'h0);
      chk("t6_drop_miss", 32'(bif.mispredict), 32'd1);
      chk("t6_drop_redirect", bif.redirect_pc, 32'ha0);
      chk("t6_drop_count", 32'(bif.count), 32'd0);
      chk("t6_perr_still", 32'(bif.protocol_err), 32'd1);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
